// File: rtl/mips_pkg.sv
// mips_pkg
// Shared types and constants for the MEM stage.
//   mem_state_e  : MEM-stage access FSM states (IDLE, WAIT)
//   DMEM_TIMEOUT : default number of WAIT cycles allowed before an access is abandoned
//   CNT_W        : width of the WAIT-cycle counter (covers TIMEOUT up to 255)
package mips_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    localparam int unsigned DMEM_TIMEOUT = 16;
    localparam int          CNT_W        = 8;

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr
// Counts WAIT cycles of an outstanding data-memory access.
// The count saturates at TIMEOUT-1, and expired_o is asserted while it sits there.
//   clk       in  : rising-edge clock
//   rst_n     in  : asynchronous active-low reset, count forced to 0
//   clear_i   in  : synchronous clear, takes priority over enable_i
//   enable_i  in  : advance the count by one this cycle
//   expired_o out : count has reached TIMEOUT-1
module mem_timeout_ctr
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// This is the pipeline MEM stage. It has a blocking data-memory handshake and a timeout.
// ALU-only instructions pass to MEM/WB after one cycle.
// An aligned load or store issues a registered dmem request and stalls the pipeline until dmem_ack arrives.
// A misaligned load or store is dropped and pulses misalign_err.
// An access that times out is abandoned and pulses bus_err.
//
// state | meaning
// IDLE  | no access outstanding; the EX/MEM slot is handled in the same cycle
// WAIT  | dmem_req held; waiting for dmem_ack or the timeout; stall high
//
// Ports
//   clk, rst_n                      : clock, asynchronous active-low reset
//   ex_valid, MemRead, MemWrite,
//   RegWrite, MemtoReg, AluResult,
//   StoreData, RegDest              : EX/MEM slot, held by upstream while stall is high
//   dmem_req/we/addr/wdata (out)    : data-memory request, stable until ack or timeout
//   dmem_ack, dmem_rdata (in)       : completion pulse and load data
//   stall (out)                     : high in WAIT
//   RegWrite_out .. RegDest_out     : MEM/WB payload, bubble (all zero) when there is no result
//   misalign_err, bus_err (out)     : one-cycle error pulses
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [31:0] AluResult,
    input  logic [31:0] StoreData,
    input  logic [4:0]  RegDest,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] AluResult_out,
    output logic [31:0] MemData_out,
    output logic [4:0]  RegDest_out,
    output logic        misalign_err,
    output logic        bus_err
);

    mem_state_e  state_q, state_d;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    // Payload of the access in flight, replayed to MEM/WB on ack.
    logic        cap_rw_q, cap_rw_d;
    logic        cap_mtr_q, cap_mtr_d;
    logic [31:0] cap_alu_q, cap_alu_d;
    logic [4:0]  cap_rd_q, cap_rd_d;
    logic        cap_load_q, cap_load_d;

    logic        rw_out_q, rw_out_d;
    logic        mtr_out_q, mtr_out_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] mem_out_q, mem_out_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic        mem_op;
    logic        expired;

    assign mem_op = ex_valid & (MemRead | MemWrite);

    // The counter is held at zero in IDLE, so it always starts from 0 on entry to WAIT.
    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q == IDLE),
        .enable_i  (state_q == WAIT),
        .expired_o (expired)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cap_rw_d   = cap_rw_q;
        cap_mtr_d  = cap_mtr_q;
        cap_alu_d  = cap_alu_q;
        cap_rd_d   = cap_rd_q;
        cap_load_d = cap_load_q;
        rw_out_d   = 1'b0;
        mtr_out_d  = 1'b0;
        alu_out_d  = '0;
        mem_out_d  = '0;
        rd_out_d   = '0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (AluResult[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end else begin
                        req_d      = 1'b1;
                        we_d       = MemWrite;
                        addr_d     = AluResult;
                        wdata_d    = StoreData;
                        cap_rw_d   = RegWrite;
                        cap_mtr_d  = MemtoReg;
                        cap_alu_d  = AluResult;
                        cap_rd_d   = RegDest;
                        // When MemRead and MemWrite are both set, the access is a store.
                        cap_load_d = ~MemWrite;
                        state_d    = WAIT;
                    end
                end else if (ex_valid) begin
                    rw_out_d  = RegWrite;
                    mtr_out_d = MemtoReg;
                    alu_out_d = AluResult;
                    rd_out_d  = RegDest;
                end
            end
            WAIT: begin
                // The ack is checked before the timeout, so an ack on the last allowed cycle still completes.
                if (dmem_ack) begin
                    req_d     = 1'b0;
                    rw_out_d  = cap_rw_q;
                    mtr_out_d = cap_mtr_q;
                    alu_out_d = cap_alu_q;
                    rd_out_d  = cap_rd_q;
                    mem_out_d = cap_load_q ? dmem_rdata : 32'h0;
                    state_d   = IDLE;
                end else if (expired) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cap_rw_q   <= 1'b0;
            cap_mtr_q  <= 1'b0;
            cap_alu_q  <= '0;
            cap_rd_q   <= '0;
            cap_load_q <= 1'b0;
            rw_out_q   <= 1'b0;
            mtr_out_q  <= 1'b0;
            alu_out_q  <= '0;
            mem_out_q  <= '0;
            rd_out_q   <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cap_rw_q   <= cap_rw_d;
            cap_mtr_q  <= cap_mtr_d;
            cap_alu_q  <= cap_alu_d;
            cap_rd_q   <= cap_rd_d;
            cap_load_q <= cap_load_d;
            rw_out_q   <= rw_out_d;
            mtr_out_q  <= mtr_out_d;
            alu_out_q  <= alu_out_d;
            mem_out_q  <= mem_out_d;
            rd_out_q   <= rd_out_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign stall         = (state_q == WAIT);
    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign RegWrite_out  = rw_out_q;
    assign MemtoReg_out  = mtr_out_q;
    assign AluResult_out = alu_out_q;
    assign MemData_out   = mem_out_q;
    assign RegDest_out   = rd_out_q;
    assign misalign_err  = misalign_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Directed testbench for mem_access_stage. It runs with TIMEOUT=16.
// Each step drives inputs just after a rising edge and checks outputs one time unit after the next rising edge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, MemRead, MemWrite, RegWrite, MemtoReg;
    logic [31:0] AluResult, StoreData;
    logic [4:0]  RegDest;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, RegWrite_out, MemtoReg_out;
    logic [31:0] AluResult_out, MemData_out;
    logic [4:0]  RegDest_out;
    logic        misalign_err, bus_err;

    int vectors     = 0;
    int miscompares = 0;
    int n;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .RegWrite      (RegWrite),
        .MemtoReg      (MemtoReg),
        .AluResult     (AluResult),
        .StoreData     (StoreData),
        .RegDest       (RegDest),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .stall         (stall),
        .RegWrite_out  (RegWrite_out),
        .MemtoReg_out  (MemtoReg_out),
        .AluResult_out (AluResult_out),
        .MemData_out   (MemData_out),
        .RegDest_out   (RegDest_out),
        .misalign_err  (misalign_err),
        .bus_err       (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        MemtoReg  = 1'b0;
        AluResult = 32'h0;
        StoreData = 32'h0;
        RegDest   = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        idle_inputs();
        #3;
        chk("reset_req",    {31'h0, dmem_req},     32'h0);
        chk("reset_stall",  {31'h0, stall},        32'h0);
        chk("reset_rw",     {31'h0, RegWrite_out}, 32'h0);
        chk("reset_alu",    AluResult_out,         32'h0);
        chk("reset_errs",   {30'h0, misalign_err, bus_err}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // ALU op passes through with one cycle of latency.
        ex_valid = 1'b1; RegWrite = 1'b1; AluResult = 32'h0000_1234; RegDest = 5'd5;
        tick();
        chk("alu_rw",    {31'h0, RegWrite_out}, 32'h1);
        chk("alu_res",   AluResult_out,         32'h0000_1234);
        chk("alu_rd",    {27'h0, RegDest_out},  32'd5);
        chk("alu_mem",   MemData_out,           32'h0);
        chk("alu_stall", {31'h0, stall},        32'h0);
        idle_inputs();
        tick();
        chk("bubble_rw",  {31'h0, RegWrite_out}, 32'h0);
        chk("bubble_alu", AluResult_out,         32'h0);

        // A load gets its ack during the third WAIT cycle.
        ex_valid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b1;
        AluResult = 32'h100; RegDest = 5'd7;
        tick();
        chk("ld_stall1", {31'h0, stall},        32'h1);
        chk("ld_req",    {31'h0, dmem_req},     32'h1);
        chk("ld_we",     {31'h0, dmem_we},      32'h0);
        chk("ld_addr",   dmem_addr,             32'h100);
        chk("ld_bub",    {31'h0, RegWrite_out}, 32'h0);
        tick();
        chk("ld_stall2", {31'h0, stall},        32'h1);
        chk("ld_bub2",   {31'h0, MemtoReg_out}, 32'h0);
        tick();
        chk("ld_stall3", {31'h0, stall},        32'h1);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_ack = 1'b0;
        idle_inputs();
        chk("ld_done_stall", {31'h0, stall},        32'h0);
        chk("ld_done_req",   {31'h0, dmem_req},     32'h0);
        chk("ld_data",       MemData_out,           32'hDEAD_BEEF);
        chk("ld_mtr",        {31'h0, MemtoReg_out}, 32'h1);
        chk("ld_rw",         {31'h0, RegWrite_out}, 32'h1);
        chk("ld_rd",         {27'h0, RegDest_out},  32'd7);
        chk("ld_alu",        AluResult_out,         32'h100);

        // A store with MemRead also set must still be treated as a store.
        ex_valid = 1'b1; MemWrite = 1'b1; MemRead = 1'b1;
        AluResult = 32'h204; StoreData = 32'hA5A5_A5A5;
        tick();
        chk("st_we",    {31'h0, dmem_we}, 32'h1);
        chk("st_wdata", dmem_wdata,       32'hA5A5_A5A5);
        chk("st_addr",  dmem_addr,        32'h204);
        // EX inputs change while the store is in WAIT; the request must not move.
        idle_inputs();
        AluResult = 32'hFFFF_0000; StoreData = 32'h1111_1111;
        tick();
        chk("st_we_hold",    {31'h0, dmem_we}, 32'h1);
        chk("st_wdata_hold", dmem_wdata,       32'hA5A5_A5A5);
        chk("st_addr_hold",  dmem_addr,        32'h204);
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        tick();
        dmem_ack = 1'b0;
        idle_inputs();
        chk("st_done_req", {31'h0, dmem_req},     32'h0);
        chk("st_memdata",  MemData_out,           32'h0);
        chk("st_rw",       {31'h0, RegWrite_out}, 32'h0);
        chk("st_alu",      AluResult_out,         32'h204);

        // A misaligned load is dropped.
        ex_valid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; AluResult = 32'h102;
        tick();
        idle_inputs();
        chk("mis_err",   {31'h0, misalign_err}, 32'h1);
        chk("mis_req",   {31'h0, dmem_req},     32'h0);
        chk("mis_stall", {31'h0, stall},        32'h0);
        chk("mis_bub",   {31'h0, RegWrite_out}, 32'h0);
        tick();
        chk("mis_pulse", {31'h0, misalign_err}, 32'h0);

        // With no ack, dmem_req stays high for exactly 16 WAIT cycles.
        ex_valid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; AluResult = 32'h300;
        tick();
        idle_inputs();
        n = 0;
        while (dmem_req === 1'b1 && n < 40) begin
            n++;
            chk("to_no_err_early", {31'h0, bus_err}, 32'h0);
            tick();
        end
        chk("to_cycles", n,                     32'd16);
        chk("to_buserr", {31'h0, bus_err},      32'h1);
        chk("to_stall",  {31'h0, stall},        32'h0);
        chk("to_bub",    {31'h0, RegWrite_out}, 32'h0);
        tick();
        chk("to_pulse",  {31'h0, bus_err},      32'h0);

        // An ack on the 16th WAIT cycle completes normally.
        ex_valid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b1;
        AluResult = 32'h400; RegDest = 5'd9;
        tick();
        idle_inputs();
        repeat (15) tick();
        chk("ack16_req", {31'h0, dmem_req}, 32'h1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_ack = 1'b0;
        chk("ack16_buserr", {31'h0, bus_err},     32'h0);
        chk("ack16_data",   MemData_out,          32'hCAFE_F00D);
        chk("ack16_rd",     {27'h0, RegDest_out}, 32'd9);
        chk("ack16_req0",   {31'h0, dmem_req},    32'h0);

        // An ack that arrives while IDLE is ignored.
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        tick();
        dmem_ack = 1'b0;
        chk("idle_ack_stall", {31'h0, stall},    32'h0);
        chk("idle_ack_data",  MemData_out,       32'h0);
        chk("idle_ack_req",   {31'h0, dmem_req}, 32'h0);

        // Reset asserted during WAIT abandons the access at once.
        ex_valid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; AluResult = 32'h500;
        tick();
        idle_inputs();
        tick();
        chk("rst_pre_stall", {31'h0, stall}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_req",   {31'h0, dmem_req}, 32'h0);
        chk("rst_stall", {31'h0, stall},    32'h0);
        chk("rst_addr",  dmem_addr,         32'h0);
        chk("rst_err",   {30'h0, misalign_err, bus_err}, 32'h0);
        #1;
        rst_n = 1'b1;
        ex_valid = 1'b1; RegWrite = 1'b1; AluResult = 32'h0000_BEEF; RegDest = 5'd3;
        tick();
        idle_inputs();
        chk("post_rst_rw",     {31'h0, RegWrite_out}, 32'h1);
        chk("post_rst_alu",    AluResult_out,         32'h0000_BEEF);
        chk("post_rst_rd",     {27'h0, RegDest_out},  32'd3);
        chk("post_rst_stall",  {31'h0, stall},        32'h0);
        chk("post_rst_buserr", {31'h0, bus_err},      32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, maximum WAIT cycles without dmem_ack before an access is abandoned (legal range 2..255).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM slot holds a real instruction
- MemRead  in  1  load
- MemWrite  in  1  store
- RegWrite  in  1  writes register file
- MemtoReg  in  1  writeback selects memory data
- AluResult  in  32  effective address or ALU result
- StoreData  in  32  store word
- RegDest  in  5  destination register
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  32  word address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  memory completion, single-cycle pulse
- dmem_rdata  in  32  load data, valid with dmem_ack
- stall  out  1  upstream SHALL hold all ex_* inputs while high
- RegWrite_out, MemtoReg_out  out  1 each  to MEM/WB
- AluResult_out, MemData_out  out  32 each  to MEM/WB
- RegDest_out  out  5  to MEM/WB
- misalign_err  out  1  one-cycle pulse, unaligned access dropped
- bus_err  out  1  one-cycle pulse, access timed out
REQ-003 Clock and reset: single clock clk; reset rst_n, asynchronous assert, active-low.

Function
REQ-004 FSM states: IDLE, WAIT; stall SHALL equal (state==WAIT).
REQ-005 mem_op = ex_valid & (MemRead | MemWrite); MemWrite SHALL take priority when both set (access is a store).
REQ-006 In IDLE, ex_valid & !mem_op: next edge outputs <= inputs, MemData_out <= 0; latency 1 cycle.
REQ-007 In IDLE, !ex_valid: next edge emits bubble (RegWrite_out=0, MemtoReg_out=0, other outputs 0).
REQ-008 In IDLE, mem_op with AluResult[1:0]!=0: bubble emitted, misalign_err=1 for one cycle, no dmem_req, stay IDLE.
REQ-009 In IDLE, aligned mem_op: capture RegWrite, MemtoReg, AluResult, RegDest, load/store into internal regs; registered dmem_req=1, dmem_we, dmem_addr=AluResult, dmem_wdata=StoreData; bubble emitted; go WAIT.
REQ-010 In WAIT, dmem_req/we/addr/wdata SHALL stay stable until ack or timeout; ex_valid ignored.
REQ-011 In WAIT with dmem_ack: next edge dmem_req=0, outputs <= captured values, MemData_out <= dmem_rdata (load) or 0 (store), go IDLE; minimum memory-op latency 2 cycles from accept.
REQ-012 WAIT cycle counter SHALL clear on entry; if it reaches TIMEOUT-1 with no ack: dmem_req=0, bubble emitted, bus_err=1 for one cycle, go IDLE.
REQ-013 dmem_ack on the timeout cycle SHALL complete normally (ack wins, no bus_err).
REQ-014 dmem_ack while IDLE SHALL be ignored.
REQ-015 Outputs SHALL be bubble on every WAIT cycle before completion.

Reset
REQ-016 rst_n low SHALL immediately force state IDLE, counter 0, dmem_req/dmem_we=0, dmem_addr/dmem_wdata=0, all *_out=0, stall=0, both error pulses 0.
REQ-017 Reset mid-WAIT SHALL abandon the access without error pulse; first post-reset edge behaves as IDLE.

Structure
REQ-018 Shared package mips_pkg SHALL hold the state enum (IDLE, WAIT) and default DMEM_TIMEOUT constant.
REQ-019 Timeout counter SHALL be sub-module mem_timeout_ctr (clear, enable, expired outputs).

Verification
REQ-020 ALU op RegWrite=1, AluResult=0x0000_1234, RegDest=5 -> next cycle RegWrite_out=1, AluResult_out=0x1234, RegDest_out=5, MemData_out=0, stall never high.
REQ-021 Load AluResult=0x100, ack after 3 WAIT cycles with dmem_rdata=0xDEADBEEF -> stall high 3 cycles, dmem_addr=0x100, dmem_we=0, then MemData_out=0xDEADBEEF, MemtoReg_out=1.
REQ-022 Store AluResult=0x204, StoreData=0xA5A5A5A5 -> dmem_we=1, dmem_wdata=0xA5A5A5A5 until ack; RegWrite_out=0, MemData_out=0.
REQ-023 Load AluResult=0x102 -> misalign_err one cycle, dmem_req stays 0, bubble output.
REQ-024 Load, no ack, TIMEOUT=16 -> dmem_req drops after 16 WAIT cycles, bus_err one cycle; repeat with ack on cycle 16 -> normal completion, no bus_err.
REQ-025 rst_n low during WAIT -> dmem_req, stall, outputs 0 immediately; next ALU op completes in 1 cycle.
